irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 34 +++
 rtl/irq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared definitions for the interrupt controller.
//                Holds the default source count, the derived index width,
//                the controller state encoding and the lost-event ceiling.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

    localparam int NUM_SRC_DEFAULT = 4;
    localparam int ID_W_DEFAULT    = $clog2(NUM_SRC_DEFAULT);

    localparam logic [7:0] LOST_MAX = 8'd255;

    // IDLE: nothing requested; REQ: ExtIRQ raised, waiting for the core's
    // acknowledge; SERV: core is in its handler, waiting for exception return.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational lowest-index priority encoder.
//  Ports       : i_req  - request vector (NUM_SRC bits)
//                o_idx  - index of the lowest set bit (0 when none set)
//                o_any  - high when any bit of i_req is set
//  Revision    : 1.0  initial release
// ============================================================================
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Edge-triggered interrupt controller for a single core.
//                Rising edges on irq_src are latched into pending; the lowest
//                enabled pending source is presented to the core on ExtIRQ
//                with its index on irq_id. The core acknowledges (ExtlAck),
//                which clears that pending bit, and later returns (ERet).
//                Events arriving on an already-pending bit are counted in a
//                saturating lost-event counter.
//  Ports       : clk, reset (async, active low)
//                irq_src[NUM_SRC]       - peripheral request levels
//                mask_we, mask_wdata    - enable-mask write port
//                ExtlAck, ERet          - core handshake
//                ExtIRQ, irq_id         - request to the core
//                pending, mask          - status registers
//                lost_cnt[8]            - dropped-event counter
//  Config      : define IRQ_SYNC_EN to insert a 2-flop synchronizer on
//                irq_src (adds two cycles of event latency).
//  Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               ExtlAck,
    input  logic               ERet,
    output logic               ExtIRQ,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic [7:0]         lost_cnt
);

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [7:0]         r_lost_cnt;
    logic [ID_W-1:0]    r_irq_id;
    logic               r_ext_irq;
    irq_state_t         r_state;
    irq_state_t         w_state_nxt;

    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic               w_drop_any;
    logic [ID_W-1:0]    w_low_idx;
    logic               w_any;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src;
`endif

    assign w_event = w_src & ~r_src_q;

    // The acknowledged source is cleared on the acknowledge edge, but a fresh
    // event on that same bit in that cycle re-sets it and is not a drop.
    assign w_clr         = (r_state == ST_REQ && ExtlAck) ? (NUM_SRC'(1) << r_irq_id) : '0;
    assign w_drop_any    = |(w_event & r_pending & ~w_clr);
    assign w_pending_nxt = (r_pending & ~w_clr) | w_event;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_req (r_pending & r_mask),
        .o_idx (w_low_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)   w_state_nxt = ST_REQ;
            ST_REQ:  if (ExtlAck) w_state_nxt = ST_SERV;
            ST_SERV: if (ERet)    w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ext_irq  <= 1'b0;
            r_irq_id   <= '0;
            r_src_q    <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_lost_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // Decoded from the next state so ExtIRQ is a clean flop output.
            r_ext_irq <= (w_state_nxt == ST_REQ);
            r_src_q   <= w_src;
            r_pending <= w_pending_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_irq_id <= w_low_idx;
            end
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_drop_any && r_lost_cnt != LOST_MAX) begin
                r_lost_cnt <= r_lost_cnt + 8'd1;
            end
        end
    end

    assign ExtIRQ   = r_ext_irq;
    assign irq_id   = r_irq_id;
    assign pending  = r_pending;
    assign mask     = r_mask;
    assign lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire
